pkt_filter_buf: RTL
===================

PKT_FILTER_BUF -- requirements
Module: pkt_filter_buf

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits.
REQ-002 Parameter DEPTH, default 16: buffer entries; SHALL be a power of two, minimum 4.
REQ-003 Parameter CNT_W, default 16: width of each statistics counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_L  in  1  reset, asynchronous, active-low.
REQ-006 val, sop, eop  in  1 each  ingress word qualifier, start of packet, end of packet.
REQ-007 data  in  DATA_W  ingress payload word.
REQ-008 error  in  1  same-cycle framing-error flag from the upstream control FSM.
REQ-009 enable  in  1  port enable from the upstream control FSM.
REQ-010 out_val, out_sop, out_eop  out  1 each  egress word valid, start of packet, end of packet.
REQ-011 out_data  out  DATA_W  egress payload word.
REQ-012 out_rdy  in  1  egress ready; a word transfers when out_val and out_rdy are both 1.
REQ-013 pkt_cnt, drop_cnt  out  CNT_W each  committed-packet count and dropped-packet count.

Function
REQ-014 An ingress word is accepted only when val=1 and enable=1; when enable=0 the word SHALL be ignored with no state change.
REQ-015 The block SHALL store-and-forward: each buffer entry holds {sop, eop, data}; a packet becomes visible at egress only after its eop word is committed.
REQ-016 Pointers: wr_ptr, commit_ptr and rd_ptr, each log2(DEPTH)+1 bits wide and wrapping modulo 2*DEPTH; fill = wr_ptr-rd_ptr; the buffer is full when fill = DEPTH.
REQ-017 Ingress FSM states: IDLE, ACCUM, DISCARD.
REQ-018 Priority for every accepted word: error, then overflow, then normal framing.
REQ-019 error=1 on an accepted word: wr_ptr <= commit_ptr, word discarded, state <= IDLE; drop_cnt increments only if the state was ACCUM.
REQ-020 IDLE with sop&eop and not full: write the word, commit (commit_ptr <= wr_ptr+1), pkt_cnt++, stay in IDLE.
REQ-021 IDLE with sop&!eop and not full: write the word, state <= ACCUM.
REQ-022 IDLE with !sop: discard the word.
REQ-023 ACCUM with !sop&!eop: write the word. ACCUM with eop: write the word, commit, pkt_cnt++, state <= IDLE.
REQ-024 Overflow (accepted word while full, in IDLE or ACCUM): wr_ptr <= commit_ptr, drop_cnt++; state <= IDLE if the word has eop, else DISCARD.
REQ-025 DISCARD: discard every word; on eop, state <= IDLE.
REQ-026 Egress is first-word-fall-through: out_val = (rd_ptr != commit_ptr); out_{sop,eop,data} = entry[rd_ptr]; rd_ptr increments on a transfer.
REQ-027 Latency: the first word of a packet is presented on out_val in the cycle after its eop is accepted.
REQ-028 A read and a write or commit in the same cycle SHALL both take effect; fill uses the pre-update rd_ptr, so no bypass is required.
REQ-029 Counters SHALL saturate at all-ones.
REQ-030 out_* SHALL hold stable while out_val=1 and out_rdy=0.

Reset
REQ-031 Asserting reset_L=0 at any time SHALL asynchronously clear all pointers, pkt_cnt and drop_cnt, and set state to IDLE; out_val is 0 during reset, and any partial or committed data is lost.
REQ-032 Buffer memory is not reset; out_data is don't-care while out_val=0.

Structure
REQ-033 Shared package ctrl_pkg SHALL hold the ingress state enum (IDLE, ACCUM, DISCARD) and the default DATA_W, DEPTH and CNT_W constants.
REQ-034 Storage SHALL be a sub-module pkt_buf_mem: DEPTH x (DATA_W+2), one write port, asynchronous read port, no reset.

Verification
REQ-035 Three-word packet A1(sop), A2, A3(eop) with out_rdy=1 -> out_val rises the cycle after A3; A1..A3 egress in order with correct sop/eop; pkt_cnt=1.
REQ-036 Sop B1, B2, then sop C1 with error=1 -> B1 and B2 never egress; drop_cnt=1; buffer empty.
REQ-037 DEPTH=16, out_rdy=0, a 20-word packet -> drop_cnt=1, pkt_cnt=0; the following 2-word packet commits and egresses.
REQ-038 Single-word sop&eop packets on back-to-back cycles with out_rdy=1 -> one word egresses per cycle; pkt_cnt equals the number of packets sent.
REQ-039 reset_L pulsed low mid-packet with 5 words committed -> out_val=0 immediately, counters 0; the next packet egresses normally.
REQ-040 enable=0 during a complete packet -> no words stored, counters unchanged.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the packet filter buffer: ingress state encoding and default sizes.
package ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } ing_state_t;

endpackage

// File: rtl/pkt_buf_mem.sv
// Packet word storage: one synchronous write port, one asynchronous read port, no reset.
module pkt_buf_mem #(
  parameter int W     = 34,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_filter_buf.sv
// Store-and-forward packet buffer that drops errored or overflowing packets and counts outcomes.
//   state   | meaning
//   IDLE    | between packets, waiting for a sop word
//   ACCUM   | packet in progress, words written but not yet committed
//   DISCARD | dropping the rest of an overflowed packet until its eop
module pkt_filter_buf
  import ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              val,
  input  logic              sop,
  input  logic              eop,
  input  logic [DATA_W-1:0] data,
  input  logic              error,
  input  logic              enable,
  output logic              out_val,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_rdy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  ing_state_t    state, state_n;
  logic [PW-1:0] wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr, fill;
  logic          accept, full, xfer, we, pkt_inc, drop_inc;
  logic [DATA_W+1:0] rd_word;

  assign accept  = val & enable;
  assign fill    = wr_ptr - rd_ptr;
  assign full    = (fill == PW'(DEPTH));
  assign out_val = (rd_ptr != commit_ptr);
  assign xfer    = out_val & out_rdy;

  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    we           = 1'b0;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;
    if (accept) begin
      if (error) begin
        wr_ptr_n = commit_ptr;
        state_n  = IDLE;
        drop_inc = (state == ACCUM);
      end else if (full && (state != DISCARD)) begin
        // any accepted word arriving while full aborts the partial packet
        wr_ptr_n = commit_ptr;
        drop_inc = 1'b1;
        state_n  = eop ? IDLE : DISCARD;
      end else begin
        case (state)
          IDLE: begin
            if (sop) begin
              we       = 1'b1;
              wr_ptr_n = wr_ptr + PW'(1);
              if (eop) begin
                commit_ptr_n = wr_ptr + PW'(1);
                pkt_inc      = 1'b1;
              end else begin
                state_n = ACCUM;
              end
            end
          end
          ACCUM: begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + PW'(1);
            if (eop) begin
              commit_ptr_n = wr_ptr + PW'(1);
              pkt_inc      = 1'b1;
              state_n      = IDLE;
            end
          end
          DISCARD: if (eop) state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      if (xfer) rd_ptr <= rd_ptr + PW'(1);
      if (pkt_inc && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  pkt_buf_mem #(
    .W     (DATA_W + 2),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({sop, eop, data}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  assign {out_sop, out_eop, out_data} = rd_word;

endmodule
